quad_step_decoder: RTL and testbench

//  Upstream front-end for the up/down counter. Decodes a quadrature encoder (phases A/B, index Z) into:
//   - one-cycle step pulses plus a direction level, which drive counter enable/up_down;
//   - an index pulse, which drives counter load.

---
 rtl/quad_step_decoder_pkg.sv | 19 +
 rtl/quad_step_decoder_input_filter.sv | 38 +++
 rtl/quad_step_decoder.sv | 86 ++++++++
 tb/tb_quad_step_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/quad_step_decoder_pkg.sv
// qsd_pkg: quadrature state encoding and transition classification helpers.
//   quad_state_t : filtered {A,B} pair, values equal to the raw pair bits
//   DIR_UP       : dir level meaning "A leads B"
//   is_up        : next state is one step further along S00->S10->S11->S01->S00
//   is_illegal   : both phase bits changed at once
package qsd_pkg;
    typedef enum logic [1:0] {S00 = 2'b00, S10 = 2'b10, S11 = 2'b11, S01 = 2'b01} quad_state_t;
    localparam logic DIR_UP = 1'b1;
    // Position along the up sequence: S00=0, S10=1, S11=2, S01=3.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        return {s[0], s[1] ^ s[0]};
    endfunction
    function automatic logic is_up(input quad_state_t prev, input quad_state_t nxt);
        return gray_pos(nxt) == gray_pos(prev) + 2'd1;
    endfunction
    function automatic logic is_illegal(input quad_state_t prev, input quad_state_t nxt);
        return (prev ^ nxt) == 2'b11;
    endfunction
endpackage

// File: rtl/quad_step_decoder_input_filter.sv
// qsd_input_filter: synchroniser chain plus stability filter for one raw pin.
//   clk, rst_n : clock, async active-low reset
//   i_raw      : asynchronous raw pin
//   o_level    : filtered level, changes after FILT_LEN consecutive differing sync samples
module qsd_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_sync;
    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B/Z decoder producing step/dir/index pulses and an error tally.
//   clk, rst_n        : clock, async active-low reset
//   enable            : 1 emits step/idx_pulse/err; 0 tracks silently
//   a_in, b_in, z_in  : raw asynchronous encoder pins
//   err_clr           : synchronous clear of err_count (wins over a new error)
//   step, dir         : one-cycle step pulse, held direction (1 = up)
//   idx_pulse, err    : filtered Z rising edge pulse, illegal transition pulse
//   err_count         : saturating illegal-transition count
// Build option: define QSD_X1_DECODE_EN for x1 decoding (steps only on S10<->S11).
module quad_step_decoder
    import qsd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 z_in,
    input  logic                 err_clr,
    output logic                 step,
    output logic                 dir,
    output logic                 idx_pulse,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);
    // Pulses stay masked until the filters have had time to learn the pins after reset.
    localparam int INIT = SYNC_STAGES + FILT_LEN + 1;
    localparam int IW   = $clog2(INIT + 1);
    logic          w_a, w_b, w_z;
    quad_state_t   r_state, w_next;
    logic          r_z_d;
    logic [IW-1:0] r_init;
    logic          w_live, w_change, w_illegal, w_up, w_step, w_err, w_idx;
    qsd_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst_n(rst_n), .i_raw(a_in), .o_level(w_a)
    );
    qsd_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst_n(rst_n), .i_raw(b_in), .o_level(w_b)
    );
    qsd_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
        .clk(clk), .rst_n(rst_n), .i_raw(z_in), .o_level(w_z)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S00;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = quad_state_t'({w_a, w_b});
    end
    always_comb begin
        w_live    = r_init == IW'(INIT);
        w_change  = w_next != r_state;
        w_illegal = is_illegal(r_state, w_next);
        w_up      = is_up(r_state, w_next);
`ifdef QSD_X1_DECODE_EN
        w_step    = w_live && enable && ((r_state == S10 && w_next == S11) || (r_state == S11 && w_next == S10));
`else
        w_step    = w_live && enable && w_change && !w_illegal;
`endif
        w_err     = w_live && enable && w_illegal;
        w_idx     = w_live && enable && w_z && !r_z_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= 1'b0;
            err       <= 1'b0;
            idx_pulse <= 1'b0;
            dir       <= DIR_UP;
            err_count <= '0;
            r_z_d     <= 1'b0;
            r_init    <= '0;
        end else begin
            step      <= w_step;
            err       <= w_err;
            idx_pulse <= w_idx;
            r_z_d     <= w_z;
            if (w_live && w_change && !w_illegal) dir <= w_up;
            if (!w_live) r_init <= r_init + 1'b1;
            err_count <= err_clr ? '0 : (w_err && !(&err_count)) ? err_count + 1'b1 : err_count;
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed and randomized checks of quad_step_decoder against a window-based model.
module tb_quad_step_decoder;
    localparam int SYNC = 2, FILT = 4, EW = 2;
    localparam int INIT = SYNC + FILT + 1, HL = SYNC + FILT;
    logic clk = 0, rst_n = 0, enable = 0, a_in = 0, b_in = 0, z_in = 0, err_clr = 0;
    logic step, dir, idx_pulse, err;
    logic [EW-1:0] err_count;
    int checks = 0, errors = 0;
    int n_step, n_err, n_both, t_count, first_step;
    int exp_v;
    logic hist [3][HL];
    logic fprev [3], fcur [3];
    logic m_step, m_idx, m_err, m_dir;
    int m_cnt, m_edges;
    logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .err_clr(err_clr), .step(step), .dir(dir), .idx_pulse(idx_pulse), .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic int pos(logic a, logic b);
        for (int i = 0; i < 4; i++) if (up_seq[i] == {a, b}) return i;
        return 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < HL; k++) hist[p][k] = 0;
            fprev[p] = 0;
            fcur[p]  = 0;
        end
        m_step = 0; m_idx = 0; m_err = 0; m_dir = 1; m_cnt = 0; m_edges = 0;
    endtask

    // One clock edge of the model: outputs come from the filtered pair change seen one edge
    // earlier; each filter flips once the last FILT synchronised samples all disagree with it.
    task automatic m_edge();
        logic pins [3];
        logic live, en, up, flip;
        int nchg;
        pins[0] = a_in; pins[1] = b_in; pins[2] = z_in;
        m_edges++;
        live = m_edges > INIT;
        en   = live && enable;
        nchg = int'(fprev[0] != fcur[0]) + int'(fprev[1] != fcur[1]);
        up   = pos(fcur[0], fcur[1]) == (pos(fprev[0], fprev[1]) + 1) % 4;
`ifdef QSD_X1_DECODE_EN
        m_step = en && nchg == 1 && fprev[0] && fcur[0];
`else
        m_step = en && nchg == 1;
`endif
        m_err = en && nchg == 2;
        m_idx = en && fcur[2] && !fprev[2];
        if (live && nchg == 1) m_dir = up;
        if (err_clr) m_cnt = 0;
        else if (m_err && m_cnt < (1 << EW) - 1) m_cnt++;
        for (int p = 0; p < 3; p++) begin
            for (int k = HL - 1; k > 0; k--) hist[p][k] = hist[p][k-1];
            hist[p][0] = pins[p];
            flip = 1;
            for (int k = SYNC; k < HL; k++) if (hist[p][k] == fcur[p]) flip = 0;
            fprev[p] = fcur[p];
            if (flip) fcur[p] = !fcur[p];
        end
    endtask

    task automatic compare();
        chk("step", int'(step), int'(m_step));
        chk("dir", int'(dir), int'(m_dir));
        chk("idx_pulse", int'(idx_pulse), int'(m_idx));
        chk("err", int'(err), int'(m_err));
        chk("err_count", int'(err_count), m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic clr_counts();
        n_step = 0; n_err = 0; n_both = 0; t_count = 0; first_step = -1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            t_count++;
            if (step) begin
                n_step++;
                if (first_step < 0) first_step = t_count;
            end
            if (err) n_err++;
            if (step && idx_pulse) n_both++;
        end
    endtask

    task automatic do_reset(int n);
        rst_n = 0;
        m_reset();
        #1;
        chk("rst_step", int'(step), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_idx", int'(idx_pulse), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_count", int'(err_count), 0);
        for (int i = 0; i < n; i++) tick();
        rst_n = 1;
    endtask

    task automatic set_ab(logic a, logic b);
        a_in = a;
        b_in = b;
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        enable = 1;
        do_reset(3);
        run(10);
        // 1: forward sequence
        clr_counts();
        set_ab(1, 0); run(20);
        set_ab(1, 1); run(20);
        set_ab(0, 1); run(20);
        set_ab(0, 0); run(20);
`ifdef QSD_X1_DECODE_EN
        chk("t1_steps", n_step, 1);
        chk("t1_first", first_step, 27);
`else
        chk("t1_steps", n_step, 4);
        chk("t1_first", first_step, 7);
`endif
        chk("t1_dir", int'(dir), 1);
        // 2: reverse sequence
        clr_counts();
        set_ab(0, 1); run(20);
        set_ab(1, 1); run(20);
        set_ab(1, 0); run(20);
        set_ab(0, 0); run(20);
`ifdef QSD_X1_DECODE_EN
        chk("t2_steps", n_step, 1);
`else
        chk("t2_steps", n_step, 4);
`endif
        chk("t2_dir", int'(dir), 0);
        // 3: short glitch on A
        clr_counts();
        a_in = 1; run(3);
        a_in = 0; run(20);
        chk("t3_steps", n_step, 0);
        chk("t3_errs", n_err, 0);
        // 4: double-bit jumps, saturating tally, clear
        clr_counts();
        set_ab(1, 1); run(20); chk("t4_cnt1", int'(err_count), 1);
        set_ab(0, 0); run(20); chk("t4_cnt2", int'(err_count), 2);
        set_ab(1, 1); run(20); chk("t4_cnt3", int'(err_count), 3);
        set_ab(0, 0); run(20); chk("t4_cnt_sat", int'(err_count), 3);
        chk("t4_errs", n_err, 4);
        chk("t4_steps", n_step, 0);
        chk("t4_dir", int'(dir), 0);
        err_clr = 1; run(1); err_clr = 0; run(1);
        chk("t4_clr", int'(err_count), 0);
        // 5: movement while disabled
        clr_counts();
        enable = 0;
        set_ab(1, 0); run(20);
        set_ab(1, 1); run(20);
        enable = 1; run(20);
        chk("t5_quiet", n_step, 0);
        set_ab(0, 1); run(20);
`ifdef QSD_X1_DECODE_EN
        exp_v = 0;
`else
        exp_v = 1;
`endif
        chk("t5_steps", n_step, exp_v);
        chk("t5_dir", int'(dir), 1);
        // 6: index coincident with a step, then reset mid-run
        set_ab(0, 0); run(20);
        set_ab(1, 0); run(20);
        clr_counts();
        set_ab(1, 1); z_in = 1; run(20);
        chk("t6_both", n_both, 1);
        z_in = 0; run(20);
        a_in = 0; run(3);
        set_ab(1, 1);
        do_reset(2);
        clr_counts();
        run(15);
        chk("t6_resync_steps", n_step, 0);
        chk("t6_resync_errs", n_err, 0);
        // randomized phase
        for (int seg = 0; seg < 600; seg++) begin
            {a_in, b_in, z_in} = 3'($urandom_range(0, 7));
            for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                enable  = ($urandom_range(0, 7) != 0);
                err_clr = ($urandom_range(0, 15) == 0);
                run(1);
            end
            if (seg == 300) do_reset(2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
